lb_router: RTL and testbench

LB_ROUTER -- requirements
Module: lb_router

---
 rtl/lb_router_pkg.sv | 22 ++
 rtl/lb_router_tmr.sv | 40 ++++
 rtl/lb_router.sv | 232 +++++++++++++++++++++++
 tb/tb_lb_router.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_router_pkg.sv
// Shared types and helpers for the local-bus router: FSM states, op encoding
// and child-index extraction from a master address.
package lb_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

  // Child index = address bits above the child address field.
  function automatic logic [31:0] chld_idx(input logic [31:0] addr,
                                           input int unsigned chld_addr_w);
    return addr >> chld_addr_w;
  endfunction

endpackage

// File: rtl/lb_router_tmr.sv
// Child response timer: saturating up-counter, cleared outside BUSY.
// expired is high while the count sits at limit.
module lb_router_tmr #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, then increment, holding at limit so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != limit)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == limit);

endmodule

// File: rtl/lb_router.sv
// Local-bus router: forwards one master transaction at a time to a child
// selected by the upper address bits, with timeout and bad-index error responses.
module lb_router
  import lb_router_pkg::*;
#(
  parameter int LB_DATA_W        = 32,
  parameter int LB_ADDR_W        = 16,
  parameter int LB_CHLD_ADDR_W   = 12,
  parameter int NUM_CHILDREN     = 4,
  parameter int TIMEOUT_CYCLES   = 64,
  parameter int REGISTER_OUTPUTS = 1,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 32'hdeadbabe
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 lb_wr_en,
  input  logic                                 lb_rd_en,
  input  logic [LB_ADDR_W-1:0]                 lb_addr,
  input  logic [LB_DATA_W-1:0]                 lb_wr_data,
  output logic                                 lb_wr_valid,
  output logic                                 lb_rd_valid,
  output logic [LB_DATA_W-1:0]                 lb_rd_data,
  output logic                                 lb_err,
  output logic                                 lb_busy,
  output logic [NUM_CHILDREN-1:0]              chld_lb_wr_en,
  output logic [NUM_CHILDREN-1:0]              chld_lb_rd_en,
  output logic [NUM_CHILDREN*LB_CHLD_ADDR_W-1:0] chld_lb_addr,
  output logic [NUM_CHILDREN*LB_DATA_W-1:0]    chld_lb_wr_data,
  input  logic [NUM_CHILDREN-1:0]              chld_lb_wr_valid,
  input  logic [NUM_CHILDREN-1:0]              chld_lb_rd_valid,
  input  logic [NUM_CHILDREN*LB_DATA_W-1:0]    chld_lb_rd_data
);

  localparam int IDX_W = LB_ADDR_W - LB_CHLD_ADDR_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMR_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [LB_CHLD_ADDR_W-1:0] addr_q, addr_d;
  logic [LB_DATA_W-1:0]      wdata_q, wdata_d;
  logic                      dual_q, dual_d;
  logic [NUM_CHILDREN-1:0]   wr_en_q, wr_en_d;
  logic [NUM_CHILDREN-1:0]   rd_en_q, rd_en_d;
  logic                      wr_valid_q, wr_valid_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      err_q, err_d;
  logic [LB_DATA_W-1:0]      rd_data_q, rd_data_d;
  logic                      busy_q, busy_d;

  logic [31:0]               idx_full_s;
  logic                      idx_ok_s;
  logic [NUM_CHILDREN-1:0]   dec_s;
  logic [NUM_CHILDREN-1:0]   hit_s;
  logic [LB_DATA_W-1:0]      chld_rd_data_a [NUM_CHILDREN];
  logic [LB_DATA_W-1:0]      sel_rd_data_s;
  logic                      sel_wr_vld_s;
  logic                      sel_rd_vld_s;
  logic                      accept_s;
  logic                      timeout_s;
  logic                      tmr_expired_s;
  logic                      comb_wr_s;
  logic                      comb_rd_s;

  assign idx_full_s = chld_idx(32'(lb_addr), LB_CHLD_ADDR_W);
  assign idx_ok_s   = (idx_full_s < 32'(NUM_CHILDREN));

  for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_chld
    assign dec_s[i]          = (idx_full_s == 32'(i));
    assign hit_s[i]          = (idx_q == IDX_W'(i));
    assign chld_rd_data_a[i] = chld_lb_rd_data[i*LB_DATA_W +: LB_DATA_W];
    assign chld_lb_addr[i*LB_CHLD_ADDR_W +: LB_CHLD_ADDR_W] = addr_q;
    assign chld_lb_wr_data[i*LB_DATA_W +: LB_DATA_W]        = wdata_q;
  end

  assign chld_lb_wr_en = wr_en_q;
  assign chld_lb_rd_en = rd_en_q;
  assign sel_wr_vld_s  = |(chld_lb_wr_valid & hit_s);
  assign sel_rd_vld_s  = |(chld_lb_rd_valid & hit_s);

  // Read-data mux for the selected child; unselected lanes are masked to zero.
  always_comb begin
    sel_rd_data_s = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      sel_rd_data_s = sel_rd_data_s | (chld_rd_data_a[i] & {LB_DATA_W{hit_s[i]}});
    end
  end

  assign accept_s  = (state_q == ST_BUSY) &&
                     ((op_q == OP_WR) ? sel_wr_vld_s : sel_rd_vld_s);
  // A child valid in the expiry cycle takes priority over the timeout.
  assign timeout_s = (state_q == ST_BUSY) && tmr_expired_s && !accept_s;

  lb_router_tmr #(
    .CNT_W (CNT_W)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != ST_BUSY),
    .en      ((state_q == ST_BUSY) && !accept_s),
    .limit   (TMR_LIMIT),
    .expired (tmr_expired_s)
  );

  // Next-state, request latch and response generation.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dual_d     = dual_q;
    wr_en_d    = '0;
    rd_en_d    = '0;
    wr_valid_d = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (lb_wr_en || lb_rd_en) begin
          op_d    = lb_wr_en ? OP_WR : OP_RD;
          idx_d   = idx_full_s[IDX_W-1:0];
          addr_d  = lb_addr[LB_CHLD_ADDR_W-1:0];
          wdata_d = lb_wr_data;
          dual_d  = lb_wr_en && lb_rd_en;
          if (idx_ok_s) begin
            state_d = ST_BUSY;
            if (lb_wr_en) begin
              wr_en_d = dec_s;
            end else begin
              rd_en_d = dec_s;
            end
          end else begin
            state_d    = ST_RESP;
            wr_valid_d = lb_wr_en;
            rd_valid_d = !lb_wr_en;
            err_d      = 1'b1;
            if (!lb_wr_en) begin
              rd_data_d = DEFAULT_DATA_VAL;
            end else begin
              rd_data_d = rd_data_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (accept_s) begin
          if (op_q == OP_RD) begin
            rd_data_d = sel_rd_data_s;
          end else begin
            rd_data_d = rd_data_q;
          end
          if (REGISTER_OUTPUTS != 0) begin
            state_d    = ST_RESP;
            wr_valid_d = (op_q == OP_WR);
            rd_valid_d = (op_q == OP_RD);
            err_d      = dual_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout_s) begin
          state_d    = ST_RESP;
          wr_valid_d = (op_q == OP_WR);
          rd_valid_d = (op_q == OP_RD);
          err_d      = 1'b1;
          if (op_q == OP_RD) begin
            rd_data_d = DEFAULT_DATA_VAL;
          end else begin
            rd_data_d = rd_data_q;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WR;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dual_q     <= 1'b0;
      wr_en_q    <= '0;
      rd_en_q    <= '0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dual_q     <= dual_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
    end
  end

  // Unregistered mode answers in the child's valid cycle; error paths stay registered.
  assign comb_wr_s   = (REGISTER_OUTPUTS == 0) && accept_s && (op_q == OP_WR);
  assign comb_rd_s   = (REGISTER_OUTPUTS == 0) && accept_s && (op_q == OP_RD);
  assign lb_wr_valid = wr_valid_q | comb_wr_s;
  assign lb_rd_valid = rd_valid_q | comb_rd_s;
  assign lb_err      = err_q | ((comb_wr_s | comb_rd_s) & dual_q);
  assign lb_rd_data  = comb_rd_s ? sel_rd_data_s : rd_data_q;
  assign lb_busy     = busy_q;

endmodule

// File: tb/tb_lb_router.sv
// Directed bench for lb_router: a registered-output and an unregistered-output
// instance share stimulus; responses are checked by per-instance scoreboards.
module tb_lb_router;

  typedef struct {
    bit          is_wr;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         lb_wr_en   = 1'b0;
  logic         lb_rd_en   = 1'b0;
  logic [15:0]  lb_addr    = 16'h0;
  logic [31:0]  lb_wr_data = 32'h0;
  logic [3:0]   c_wr_vld   = 4'h0;
  logic [3:0]   c_rd_vld   = 4'h0;
  logic [127:0] c_rd_data  = 128'h0;

  logic [1:0]   o_wr_vld, o_rd_vld, o_err, o_busy;
  logic [31:0]  o_rd_data [2];
  logic [3:0]   o_cwr [2];
  logic [3:0]   o_crd [2];
  logic [47:0]  o_caddr [2];
  logic [127:0] o_cwdata [2];

  exp_t q_reg[$];
  exp_t q_cmb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lb_router #(.TIMEOUT_CYCLES(8), .REGISTER_OUTPUTS(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en),
    .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_wr_valid(o_wr_vld[0]), .lb_rd_valid(o_rd_vld[0]), .lb_rd_data(o_rd_data[0]),
    .lb_err(o_err[0]), .lb_busy(o_busy[0]),
    .chld_lb_wr_en(o_cwr[0]), .chld_lb_rd_en(o_crd[0]),
    .chld_lb_addr(o_caddr[0]), .chld_lb_wr_data(o_cwdata[0]),
    .chld_lb_wr_valid(c_wr_vld), .chld_lb_rd_valid(c_rd_vld), .chld_lb_rd_data(c_rd_data)
  );

  lb_router #(.TIMEOUT_CYCLES(8), .REGISTER_OUTPUTS(0)) u_cmb (
    .clk(clk), .rst_n(rst_n), .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en),
    .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_wr_valid(o_wr_vld[1]), .lb_rd_valid(o_rd_vld[1]), .lb_rd_data(o_rd_data[1]),
    .lb_err(o_err[1]), .lb_busy(o_busy[1]),
    .chld_lb_wr_en(o_cwr[1]), .chld_lb_rd_en(o_crd[1]),
    .chld_lb_addr(o_caddr[1]), .chld_lb_wr_data(o_cwdata[1]),
    .chld_lb_wr_valid(c_wr_vld), .chld_lb_rd_valid(c_rd_vld), .chld_lb_rd_data(c_rd_data)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit w, input bit e, input logic [31:0] d, input int c);
    exp_t x;
    x.is_wr = w;
    x.err   = e;
    x.data  = d;
    x.cyc   = c;
    return x;
  endfunction

  task automatic push2(input bit w, input bit e, input logic [31:0] d,
                       input int c_reg, input int c_cmb);
    q_reg.push_back(mk(w, e, d, c_reg));
    q_cmb.push_back(mk(w, e, d, c_cmb));
  endtask

  task automatic check_resp(input int k, input exp_t e);
    string p;
    p = (k == 0) ? "reg" : "cmb";
    chk({p, "_wr_valid"}, o_wr_vld[k], e.is_wr);
    chk({p, "_rd_valid"}, o_rd_vld[k], !e.is_wr);
    chk({p, "_err"}, o_err[k], e.err);
    chk({p, "_resp_cycle"}, cyc, e.cyc);
    if (!e.is_wr) chk({p, "_rd_data"}, o_rd_data[k], e.data);
  endtask

  // Response monitor: every master valid must match the head of its queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_wr_vld[k] || o_rd_vld[k]) begin
        if (k == 0 && q_reg.size() > 0) check_resp(k, q_reg.pop_front());
        else if (k == 1 && q_cmb.size() > 0) check_resp(k, q_cmb.pop_front());
        else chk((k == 0) ? "reg_unexpected_resp" : "cmb_unexpected_resp", 1'b1, 1'b0);
      end else begin
        chk((k == 0) ? "reg_err_without_valid" : "cmb_err_without_valid", o_err[k], 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic issue(input bit w, input bit r, input logic [15:0] a, input logic [31:0] d);
    lb_wr_en = w; lb_rd_en = r; lb_addr = a; lb_wr_data = d;
    tick();
    lb_wr_en = 1'b0; lb_rd_en = 1'b0;
  endtask

  task automatic chk_child(input string tag, input logic [3:0] wr, input logic [3:0] rd);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_chld_wr_en"}, o_cwr[k], wr);
      chk({tag, "_chld_rd_en"}, o_crd[k], rd);
    end
  endtask

  task automatic chk_lane(input string tag, input int ch, input logic [11:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_chld_addr"}, o_caddr[k][ch*12 +: 12], a);
      chk({tag, "_chld_wr_data"}, o_cwdata[k][ch*32 +: 32], d);
      chk({tag, "_busy"}, o_busy[k], 1'b1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_busy"}, o_busy[k], 1'b0);
      chk({tag, "_valids"}, {o_wr_vld[k], o_rd_vld[k], o_err[k]}, 3'b000);
      chk({tag, "_rd_data"}, o_rd_data[k], 32'h0);
      chk({tag, "_chld_strobes"}, {o_cwr[k], o_crd[k]}, 8'h00);
      chk({tag, "_chld_addr"}, o_caddr[k], 48'h0);
      chk({tag, "_chld_wr_data"}, o_cwdata[k], 128'h0);
    end
  endtask

  initial begin
    int t0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Write to child 1, child completes at t3.
    t0 = cyc;
    push2(1'b1, 1'b0, 32'h0, t0 + 4, t0 + 3);
    issue(1'b1, 1'b0, 16'h1010, 32'hA5A5A5A5);
    chk_child("wr_t1", 4'b0010, 4'b0000);
    chk_lane("wr_t1", 1, 12'h010, 32'hA5A5A5A5);
    tick();
    chk_child("wr_t2", 4'b0000, 4'b0000);
    tick();
    c_wr_vld = 4'b0010;
    tick();
    c_wr_vld = 4'b0000;
    wait_to(t0 + 8);

    // Read from child 2, zero-latency child.
    t0 = cyc;
    push2(1'b0, 1'b0, 32'h12345678, t0 + 2, t0 + 1);
    issue(1'b0, 1'b1, 16'h2004, 32'h0);
    c_rd_vld = 4'b0100;
    c_rd_data[64 +: 32] = 32'h12345678;
    chk_child("rd0_t1", 4'b0000, 4'b0100);
    chk_lane("rd0_t1", 2, 12'h004, 32'h0);
    tick();
    c_rd_vld = 4'b0000;
    wait_to(t0 + 6);

    // Read to a nonexistent child.
    t0 = cyc;
    push2(1'b0, 1'b1, 32'hDEADBABE, t0 + 1, t0 + 1);
    issue(1'b0, 1'b1, 16'hF000, 32'h0);
    chk_child("badidx_t1", 4'b0000, 4'b0000);
    wait_to(t0 + 4);

    // Read to silent child 0: timeout, then a late valid that must be ignored.
    t0 = cyc;
    push2(1'b0, 1'b1, 32'hDEADBABE, t0 + 9, t0 + 9);
    issue(1'b0, 1'b1, 16'h0000, 32'h0);
    chk_child("tmo_t1", 4'b0000, 4'b0001);
    wait_to(t0 + 12);
    c_rd_vld = 4'b0001;
    c_rd_data[31:0] = 32'h11111111;
    tick();
    c_rd_vld = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      chk("late_valid_rd_data_hold", o_rd_data[k], 32'hDEADBABE);
      chk("late_valid_busy", o_busy[k], 1'b0);
    end
    wait_to(t0 + 15);

    // Write and read together, plus a strobe while busy.
    t0 = cyc;
    push2(1'b1, 1'b1, 32'h0, t0 + 5, t0 + 4);
    issue(1'b1, 1'b1, 16'h0008, 32'hCAFEF00D);
    chk_child("dual_t1", 4'b0001, 4'b0000);
    chk_lane("dual_t1", 0, 12'h008, 32'hCAFEF00D);
    tick();
    lb_rd_en = 1'b1;
    lb_addr  = 16'h1000;
    tick();
    lb_rd_en = 1'b0;
    chk_child("busy_strobe_t3", 4'b0000, 4'b0000);
    tick();
    c_wr_vld = 4'b0001;
    tick();
    c_wr_vld = 4'b0000;
    wait_to(t0 + 9);

    // Reset during BUSY aborts the read; the next read completes.
    t0 = cyc;
    issue(1'b0, 1'b1, 16'h3ABC, 32'h55AA55AA);
    chk_child("abort_t1", 4'b0000, 4'b1000);
    chk_lane("abort_t1", 3, 12'hABC, 32'h55AA55AA);
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    c_rd_vld = 4'b1000;
    c_rd_data[96 +: 32] = 32'h77777777;
    tick();
    rst_n    = 1'b1;
    c_rd_vld = 4'b0000;
    repeat (2) tick();

    t0 = cyc;
    push2(1'b0, 1'b0, 32'h0BADF00D, t0 + 3, t0 + 2);
    issue(1'b0, 1'b1, 16'h3123, 32'h0);
    chk_child("postrst_t1", 4'b0000, 4'b1000);
    chk_lane("postrst_t1", 3, 12'h123, 32'h0);
    tick();
    c_rd_vld = 4'b1000;
    c_rd_data[96 +: 32] = 32'h0BADF00D;
    tick();
    c_rd_vld = 4'b0000;
    wait_to(t0 + 8);

    chk("reg_queue_drained", q_reg.size(), 0);
    chk("cmb_queue_drained", q_cmb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
